// File: rtl/fp_div_if.sv
// Operand/result bundle for the single-precision divider.
interface fp_div_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output a, b, start,
    input  result, done, busy, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  a, b, start,
    output result, done, busy, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider: restoring mantissa division, one bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_divider (
  input logic      clk,
  input logic      reset_n,
  fp_div_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} state_e;

  state_e             state_q, state_d;
  logic        [31:0] result_q;
  logic               done_q;
  logic               ovf_q, unf_q, dbz_q, inv_q;
  logic               sign_q;
  logic        [23:0] mant_b_q;
  logic        [24:0] rem_q;
  logic        [25:0] quo_q;
  logic signed [9:0]  exp_q;
  logic        [4:0]  cnt_q;

  // Operand classification
  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab, accept;

  assign a_exp   = bus.a[30:23];
  assign b_exp   = bus.b[30:23];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (bus.a[22:0] == 23'h0);
  assign b_inf   = (b_exp == 8'hFF) && (bus.b[22:0] == 23'h0);
  assign a_nan   = (a_exp == 8'hFF) && (bus.a[22:0] != 23'h0);
  assign b_nan   = (b_exp == 8'hFF) && (bus.b[22:0] != 23'h0);
  assign sign_ab = bus.a[31] ^ bus.b[31];
  // The done cycle still blocks a new request even though the FSM is already idle.
  assign accept  = (state_q == StIdle) && bus.start && !done_q;

  logic        spec_hit, spec_inv, spec_dbz;
  logic [31:0] spec_result;

  always_comb begin
    spec_hit    = 1'b1;
    spec_inv    = 1'b0;
    spec_dbz    = 1'b0;
    spec_result = 32'h0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = 32'h7FC0_0000;
      spec_inv    = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_result = {sign_ab, 8'hFF, 23'h0};
      spec_dbz    = 1'b1;
    end else if (a_inf) begin
      spec_result = {sign_ab, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      spec_result = {sign_ab, 31'h0};
    end else begin
      spec_hit    = 1'b0;
    end
  end

  // One restoring step
  logic        rem_ge;
  logic [23:0] rem_sub;
  logic [24:0] rem_next;

  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mant_b_q});
    rem_sub  = rem_ge ? 24'(rem_q - {1'b0, mant_b_q}) : rem_q[23:0];
    rem_next = {rem_sub, 1'b0};
  end

  // Normalisation, rounding and range check
  logic        [22:0] mant_n;
  logic signed [9:0]  exp_n, exp_r;
  logic        [23:0] mant_r;
  logic               round_up, norm_ovf, norm_unf;
  logic        [31:0] norm_result;

  always_comb begin
    if (quo_q[25]) begin
      mant_n = quo_q[24:2];
      exp_n  = exp_q + 10'sd127;
    end else begin
      mant_n = quo_q[23:1];
      exp_n  = exp_q + 10'sd126;
    end
`ifdef FP_DIV_ROUND_EN
    begin
      logic guard, sticky;
      guard    = quo_q[25] ? quo_q[1] : quo_q[0];
      sticky   = (rem_q != 25'h0) || (quo_q[25] && quo_q[0]);
      round_up = guard && (sticky || mant_n[0]);
    end
`else
    round_up = 1'b0;
`endif
    mant_r   = {1'b0, mant_n} + {23'h0, round_up};
    exp_r    = exp_n + {9'h0, mant_r[23]};
    norm_ovf = (exp_r >= 10'sd255);
    norm_unf = !norm_ovf && (exp_r <= 10'sd0);
    if (norm_ovf) begin
      norm_result = {sign_q, 8'hFF, 23'h0};
    end else if (norm_unf) begin
      norm_result = {sign_q, 31'h0};
    end else begin
      norm_result = {sign_q, exp_r[7:0], mant_r[22:0]};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = spec_hit ? StDone : StDivide;
      StDivide: if (cnt_q == 5'd25) state_d = StNorm;
      StNorm:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.result      = result_q;
    bus.overflow    = ovf_q;
    bus.underflow   = unf_q;
    bus.div_by_zero = dbz_q;
    bus.invalid     = inv_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'h0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
      sign_q   <= 1'b0;
      mant_b_q <= 24'h0;
      rem_q    <= 25'h0;
      quo_q    <= 26'h0;
      exp_q    <= 10'sd0;
      cnt_q    <= 5'd0;
    end else begin
      done_q <= (state_q == StDone);
      if (accept) begin
        sign_q   <= sign_ab;
        mant_b_q <= {1'b1, bus.b[22:0]};
        rem_q    <= {2'b01, bus.a[22:0]};
        quo_q    <= 26'h0;
        exp_q    <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
        cnt_q    <= 5'd0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
        dbz_q    <= spec_hit && spec_dbz;
        inv_q    <= spec_hit && spec_inv;
        if (spec_hit) result_q <= spec_result;
      end else if (state_q == StDivide) begin
        rem_q <= rem_next;
        quo_q <= {quo_q[24:0], rem_ge};
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == StNorm) begin
        result_q <= norm_result;
        ovf_q    <= norm_ovf;
        unf_q    <= norm_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed corner cases plus random operands vs a model.
module tb_fp_divider;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fp_div_if bus ();

  fp_divider dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid};
  endfunction

  // Reference: exact integer quotient of the significands, then normalise/round/range check.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output bit special);
    int unsigned ea, eb, ma, mb, mant;
    bit sa, sb, s, za, zb, ia, ib, na, nb, g, st;
    longint unsigned num, q;
    int e;
    ea = a[30:23]; eb = b[30:23];
    sa = a[31];    sb = b[31];   s = sa ^ sb;
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
    special = 1'b1;
    f = 4'b0000;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7FC0_0000; f = 4'b0001;
    end else if (zb && !ia) begin
      r = {s, 8'hFF, 23'h0}; f = 4'b0010;
    end else if (ia) begin
      r = {s, 8'hFF, 23'h0};
    end else if (za || ib) begin
      r = {s, 31'h0};
    end else begin
      special = 1'b0;
      ma  = (1 << 23) | a[22:0];
      mb  = (1 << 23) | b[22:0];
      num = longint'(ma) << 25;
      q   = num / mb;
      st  = (num % mb) != 0;
      if (q >= (64'd1 << 25)) begin
        mant = int'((q >> 2) & 64'h7FFFFF); g = q[1]; st = st | q[0];
        e = int'(ea) - int'(eb) + 127;
      end else begin
        mant = int'((q >> 1) & 64'h7FFFFF); g = q[0];
        e = int'(ea) - int'(eb) + 126;
      end
`ifdef FP_DIV_ROUND_EN
      if (g && (st || mant[0])) mant = mant + 1;
`endif
      if (mant == (1 << 23)) begin
        mant = 0; e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b1000;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0100;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  // Issue one request and wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    r = bus.result;
    f = flags_now();
    @(posedge clk); #1;
    check("done_width", bus.done, 1'b0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    do_op(a, b, r, f, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, r, exp_r);
    check({tag, "_flg"}, f, exp_f);
  endtask

  task automatic random_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    bit          sp;
    int          lat;
    ref_div(a, b, er, ef, sp);
    do_op(a, b, r, f, lat);
    check("rnd_lat", lat, sp ? 1 : 28);
    check("rnd_res", r, er);
    check("rnd_flg", f, ef);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int unsigned kind;
    v    = $urandom;
    kind = $urandom_range(0, 15);
    case (kind)
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = {8'hFF, 23'h0};
      2:       v[30:0]  = {8'hFF, v[22:1], 1'b1};
      3:       v[30:23] = 8'($urandom_range(1, 8));
      4:       v[30:23] = 8'($urandom_range(246, 254));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  logic [31:0] r_tmp;
  logic [3:0]  f_tmp;
  int          lat_tmp;
  bit          done_seen;

  initial begin
    reset_n   = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.start = 1'b0;
    #3;
    check("rst_result", bus.result, 32'h0);
    check("rst_ctl", {bus.done, bus.busy, flags_now()}, 6'h0);
    @(negedge clk);
    reset_n = 1'b1;

    directed("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28);
`ifdef FP_DIV_ROUND_EN
    directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 28);
`else
    directed("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 28);
`endif
    directed("pos_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010, 1);
    directed("neg_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0010, 1);
    directed("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 1);
    directed("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001, 1);
    directed("inf_by_zero", 32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0000, 1);
    directed("x_by_inf", 32'h4040_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1);
    directed("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000, 28);
    directed("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 28);

    // A second start mid-division must be ignored.
    @(negedge clk);
    bus.a = 32'h40C0_0000; bus.b = 32'h4000_0000; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat_tmp = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) check("busy_mid", bus.busy, 1'b1);
      if (k == 9) begin
        bus.a = 32'h3F80_0000; bus.b = 32'h0; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat_tmp = k;
        break;
      end
    end
    check("restart_lat", lat_tmp, 28);
    check("restart_res", bus.result, 32'h4040_0000);
    check("restart_flg", flags_now(), 4'b0000);

    // Start held through the done cycle: ignored there, accepted on the following edge.
    bus.a = 32'h3F80_0000; bus.b = 32'h0; bus.start = 1'b1;
    @(posedge clk); #1;
    check("donecyc_busy", bus.busy, 1'b0);
    check("donecyc_res", bus.result, 32'h4040_0000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("after_done_res", bus.result, 32'h7F80_0000);
    check("after_done_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    check("after_done_pulse", bus.done, 1'b1);
    check("after_done_flg", flags_now(), 4'b0010);
    @(posedge clk); #1;

    // Reset in the middle of a division.
    @(negedge clk);
    bus.a = 32'h40C0_0000; bus.b = 32'h4040_0000; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_result", bus.result, 32'h0);
    check("midrst_ctl", {bus.done, bus.busy, flags_now()}, 6'h0);
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    check("midrst_no_done", done_seen, 1'b0);
    directed("post_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28);

    for (int i = 0; i < 80; i++) begin
      random_op(rand_operand(), rand_operand());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
